// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte sequencer: byte width and FSM state encoding.
package spi_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_KICK  = 3'd2,
    S_WAIT  = 3'd3,
    S_STORE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word fall-through FIFO with wrap-bit pointers.
// The head reads as zero while the FIFO is empty, so a freshly reset or drained
// FIFO presents a defined value and an ignored pop leaves the head unchanged.
module spi_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full FIFO is legal only when a pop frees the head slot in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; only the pointers carry reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are qualified by the pointers and need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Host-side burst front end for the SPI byte master: TX FIFO feeds the master one byte
// per START/BUSY handshake, each received byte lands in the RX FIFO, and a burst of LEN
// bytes ends with a one-cycle DONE pulse. An empty TX FIFO is padded with FILL_BYTE.
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int                DEPTH     = 16,
  parameter int                LEN_W     = 8,
  parameter logic [BYTE_W-1:0] FILL_BYTE = 8'hFF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TX_WR,
  input  logic [BYTE_W-1:0] TX_DATA,
  output logic              TX_FULL,
  input  logic              RX_RD,
  output logic [BYTE_W-1:0] RX_DATA,
  output logic              RX_EMPTY,
  input  logic              GO,
  input  logic [LEN_W-1:0]  LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              M_START,
  output logic [BYTE_W-1:0] M_DOUT,
  input  logic              M_BUSY,
  input  logic [BYTE_W-1:0] M_DIN
);

  state_t            state;
  logic [LEN_W-1:0]  count;
  logic [BYTE_W-1:0] tx_head;
  logic              tx_empty;
  logic              tx_pop;
  logic              rx_full;
  logic              rx_push;
  logic              start_q;
  logic              done_q;
  logic [BYTE_W-1:0] dout_q;

  // LOAD consumes the TX head (ignored by the FIFO when empty); STORE pushes only with room.
  assign tx_pop  = (state == S_LOAD);
  assign rx_push = (state == S_STORE) && !rx_full;

  assign BUSY    = (state != S_IDLE);
  assign DONE    = done_q;
  assign M_START = start_q;
  assign M_DOUT  = dout_q;

  spi_sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_tx_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (TX_WR),
    .push_data (TX_DATA),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (TX_FULL),
    .empty     (tx_empty)
  );

  spi_sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_rx_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (rx_push),
    .push_data (M_DIN),
    .pop       (RX_RD),
    .head      (RX_DATA),
    .full      (rx_full),
    .empty     (RX_EMPTY)
  );

  // Burst FSM with registered START/DOUT/DONE; START is high exactly while in KICK
  // and DONE is high exactly while in FIN (or the cycle after a zero-length GO).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      count   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (GO) begin
            if (LEN != '0) begin
              count <= LEN;
              state <= S_LOAD;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          dout_q  <= tx_empty ? FILL_BYTE : tx_head;
          start_q <= 1'b1;
          state   <= S_KICK;
        end
        S_KICK: begin
          if (M_BUSY) begin
            start_q <= 1'b0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!M_BUSY) state <= S_STORE;
        end
        S_STORE: begin
          if (!rx_full) begin
            count <= count - 1'b1;
            if (count == LEN_W'(1)) begin
              done_q <= 1'b1;
              state  <= S_FIN;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          start_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Bench for spi_byte_sequencer: a behavioural SPI byte master with MISO looped to MOSI,
// directed scenarios plus randomized bursts checked against a queue-based reference.
module tb_spi_byte_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_rd = 1'b0;
  logic       go = 1'b0;
  logic [7:0] len = 8'h00;
  logic       tx_full, rx_empty, busy, done, m_start;
  logic [7:0] rx_data, m_dout;

  // behavioural master state
  logic       m_busy = 1'b0;
  logic [7:0] m_din = 8'h00;
  logic [7:0] m_sh = 8'h00;
  int         m_cnt = 0;
  int         mlat = 3;
  int         frames = 0;
  int         done_cnt = 0;
  logic [7:0] sent_q[$];

  // reference model state
  logic [7:0] tx_model[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_sent[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_byte_sequencer #(.DEPTH(DEPTH), .LEN_W(8), .FILL_BYTE(8'hFF)) dut (
    .CLK      (clk),
    .RST      (rst),
    .TX_WR    (tx_wr),
    .TX_DATA  (tx_data),
    .TX_FULL  (tx_full),
    .RX_RD    (rx_rd),
    .RX_DATA  (rx_data),
    .RX_EMPTY (rx_empty),
    .GO       (go),
    .LEN      (len),
    .BUSY     (busy),
    .DONE     (done),
    .M_START  (m_start),
    .M_DOUT   (m_dout),
    .M_BUSY   (m_busy),
    .M_DIN    (m_din)
  );

  // SPI byte master: accepts START when idle, stays busy mlat cycles, returns the byte sent
  always @(posedge clk) begin
    if (!m_busy) begin
      if (m_start) begin
        m_busy <= 1'b1;
        m_sh   <= m_dout;
        m_cnt  <= mlat;
        frames <= frames + 1;
      end
    end else if (m_cnt <= 1) begin
      m_busy <= 1'b0;
      m_din  <= m_sh;
      sent_q.push_back(m_sh);
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    if (tx_model.size() < DEPTH) tx_model.push_back(b);
    tx_data = b;
    tx_wr = 1'b1;
    tick();
    tx_wr = 1'b0;
  endtask

  // Accepted GO: model the bytes sent (TX head or fill) and the looped-back RX bytes
  task automatic start_burst(input logic [7:0] n);
    logic [7:0] b;
    for (int i = 0; i < int'(n); i++) begin
      b = (tx_model.size() > 0) ? tx_model.pop_front() : 8'hFF;
      exp_sent.push_back(b);
      exp_q.push_back(b);
    end
    len = n;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic drain(input string tag, input int maxc);
    int n = 0;
    while ((busy || !rx_empty) && n < maxc) begin
      if (!rx_empty) begin
        if (exp_q.size() > 0) check({tag, "_rx"}, rx_data, exp_q.pop_front());
        else check({tag, "_rx_extra"}, rx_empty, 1'b1);
        rx_rd = 1'b1;
      end else begin
        rx_rd = 1'b0;
      end
      tick();
      n++;
    end
    rx_rd = 1'b0;
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_rx_left"}, exp_q.size(), 0);
  endtask

  task automatic check_sent(input string tag);
    check({tag, "_nsent"}, sent_q.size(), exp_sent.size());
    for (int i = 0; i < exp_sent.size() && i < sent_q.size(); i++)
      check({tag, "_mosi"}, sent_q[i], exp_sent[i]);
    sent_q.delete();
    exp_sent.delete();
  endtask

  initial begin
    int f0, d0, n;
    logic [7:0] b;

    // reset state
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_start", m_start, 1'b0);
    check("rst_dout", m_dout, 8'h00);
    check("rst_txfull", tx_full, 1'b0);
    check("rst_rxempty", rx_empty, 1'b1);
    check("rst_rxdata", rx_data, 8'h00);
    rst = 1'b0;
    tick();

    // 1: two queued bytes, LEN=2
    f0 = frames; d0 = done_cnt;
    push_tx(8'hA5);
    push_tx(8'h3C);
    start_burst(8'd2);
    check("t1_busy", busy, 1'b1);
    drain("t1", 400);
    check("t1_frames", frames - f0, 2);
    check("t1_done", done_cnt - d0, 1);
    check_sent("t1");

    // 2: empty TX pads with fill
    f0 = frames; d0 = done_cnt;
    start_burst(8'd3);
    drain("t2", 400);
    check("t2_frames", frames - f0, 3);
    check("t2_done", done_cnt - d0, 1);
    check_sent("t2");

    // 3: zero-length GO
    f0 = frames; d0 = done_cnt;
    start_burst(8'd0);
    check("t3_done_hi", done, 1'b1);
    check("t3_busy", busy, 1'b0);
    tick();
    check("t3_done_lo", done, 1'b0);
    repeat (5) tick();
    check("t3_frames", frames - f0, 0);
    check("t3_done_cnt", done_cnt - d0, 1);

    // 4: RX back-pressure stalls in STORE, then resumes when drained
    f0 = frames; d0 = done_cnt;
    mlat = 2;
    for (int i = 1; i <= 4; i++) push_tx(8'(i));
    start_burst(8'd6);
    n = 0;
    while (frames - f0 < 5 && n < 300) begin tick(); n++; end
    repeat (20) tick();
    check("t4_stall_frames", frames - f0, 5);
    check("t4_stall_busy", busy, 1'b1);
    check("t4_stall_rxempty", rx_empty, 1'b0);
    check("t4_stall_done", done_cnt - d0, 0);
    drain("t4", 400);
    check("t4_frames", frames - f0, 6);
    check("t4_done", done_cnt - d0, 1);
    check_sent("t4");

    // 5: push while full is dropped; GO mid-burst is ignored
    f0 = frames; d0 = done_cnt;
    for (int i = 0; i < 4; i++) push_tx(8'($urandom_range(0, 255)));
    check("t5_full", tx_full, 1'b1);
    push_tx(8'h11);
    check("t5_full_after", tx_full, 1'b1);
    start_burst(8'd5);
    repeat (3) tick();
    len = 8'd2;
    go = 1'b1;
    tick();
    go = 1'b0;
    drain("t5", 400);
    check("t5_frames", frames - f0, 5);
    check("t5_done", done_cnt - d0, 1);
    check_sent("t5");

    // 6: reset in WAIT of byte 2, then a clean single-byte burst
    f0 = frames;
    mlat = 8;
    for (int i = 0; i < 4; i++) push_tx(8'($urandom_range(0, 255)));
    start_burst(8'd4);
    n = 0;
    while (frames - f0 < 2 && n < 300) begin tick(); n++; end
    tick();
    tick();
    check("t6_in_wait", {m_busy, m_start, busy}, 3'b101);
    rst = 1'b1;
    #1;
    check("t6_busy", busy, 1'b0);
    check("t6_start", m_start, 1'b0);
    check("t6_dout", m_dout, 8'h00);
    check("t6_done", done, 1'b0);
    check("t6_txfull", tx_full, 1'b0);
    check("t6_rxempty", rx_empty, 1'b1);
    check("t6_rxdata", rx_data, 8'h00);
    tick();
    rst = 1'b0;
    tx_model.delete();
    exp_q.delete();
    exp_sent.delete();
    n = 0;
    while (m_busy && n < 100) begin tick(); n++; end
    tick();
    sent_q.delete();
    f0 = frames; d0 = done_cnt;
    mlat = 3;
    push_tx(8'h5A);
    start_burst(8'd1);
    drain("t6b", 400);
    check("t6b_frames", frames - f0, 1);
    check("t6b_done", done_cnt - d0, 1);
    check_sent("t6b");

    // randomized bursts
    for (int it = 0; it < 8; it++) begin
      f0 = frames; d0 = done_cnt;
      mlat = $urandom_range(1, 5);
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom_range(0, 255));
        push_tx(b);
      end
      n = $urandom_range(1, 7);
      start_burst(8'(n));
      drain("rnd", 600);
      check("rnd_frames", frames - f0, n);
      check("rnd_done", done_cnt - d0, 1);
      check_sent("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
